// File: rtl/noc_vc_output_port.sv
// Router output port: N_IN input lanes share N_VC virtual channels on one
// physical link. Each VC is wormhole-locked from head to tail and picks its
// owner round-robin among the inputs. Unlocked VCs accept only head flits.
// VCs interleave flit by flit in round-robin order, and a VC may send only
// while it holds downstream credit. The output is registered and err_o is a
// sticky flag for protocol violations.
module noc_vc_output_port #(
    parameter int N_IN      = 4,
    parameter int N_VC      = 4,
    parameter int FLIT_W    = 34,
    parameter int BUF_DEPTH = 4,
    localparam int VC_W     = (N_VC > 1) ? $clog2(N_VC) : 1,
    localparam int CNT_W    = $clog2(BUF_DEPTH + 1),
    localparam int LANE_W   = 1 + VC_W + FLIT_W
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic [N_IN*LANE_W-1:0]   fin_req_i,
    output logic [N_IN-1:0]          fin_resp_o,
    output logic [LANE_W-1:0]        fout_req_o,
    input  logic [VC_W:0]            fout_resp_i,
    output logic                     err_o
);

    localparam int IN_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic [1:0] {
        FT_HEAD     = 2'b00,
        FT_BODY     = 2'b01,
        FT_TAIL     = 2'b10,
        FT_HEADTAIL = 2'b11
    } flit_type_t;

    typedef enum logic {
        VC_UNLOCKED = 1'b0,
        VC_LOCKED   = 1'b1
    } lock_state_t;

    function automatic logic is_head(input flit_type_t t);
        return (t == FT_HEAD) || (t == FT_HEADTAIL);
    endfunction

    // Unpacked view of the input lanes.
    logic [N_IN-1:0]   w_lane_valid;
    logic [VC_W-1:0]   w_lane_vc   [N_IN];
    logic [FLIT_W-1:0] w_lane_flit [N_IN];
    flit_type_t        w_lane_type [N_IN];

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_lane
        assign w_lane_valid[gi] = fin_req_i[gi*LANE_W + LANE_W - 1];
        assign w_lane_vc[gi]    = fin_req_i[gi*LANE_W + FLIT_W +: VC_W];
        assign w_lane_flit[gi]  = fin_req_i[gi*LANE_W +: FLIT_W];
        assign w_lane_type[gi]  = flit_type_t'(w_lane_flit[gi][FLIT_W-1 -: 2]);
    end

    // Per-VC state and pointers.
    lock_state_t       r_lock   [N_VC];
    logic [IN_W-1:0]   r_owner  [N_VC];
    logic [IN_W-1:0]   r_in_ptr [N_VC];
    logic [CNT_W-1:0]  r_credit [N_VC];
    logic [VC_W-1:0]   r_vc_ptr;
    logic [LANE_W-1:0] r_fout;
    logic              r_err;

    // Credit return decode.
    logic            w_cr_valid;
    logic [VC_W-1:0] w_cr_vc;
    assign w_cr_valid = fout_resp_i[VC_W];
    assign w_cr_vc    = fout_resp_i[VC_W-1:0];

    // Per-VC candidate: owner's next body/tail if locked, else RR head search.
    logic [N_VC-1:0] w_cand_valid;
    logic [IN_W-1:0] w_cand_in [N_VC];

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        int  idx;
        int  own;
        logic found;
        idx   = 0;
        own   = 0;
        found = 1'b0;
        for (int v = 0; v < N_VC; v++) begin
            w_cand_valid[v] = 1'b0;
            w_cand_in[v]    = '0;
            found           = 1'b0;
            if (r_lock[v] == VC_UNLOCKED) begin
                for (int k = 0; k < N_IN; k++) begin
                    idx = (int'(r_in_ptr[v]) + k) % N_IN;
                    if (!found && w_lane_valid[idx] && int'(w_lane_vc[idx]) == v &&
                        is_head(w_lane_type[idx])) begin
                        found        = 1'b1;
                        w_cand_in[v] = IN_W'(idx);
                    end
                end
                w_cand_valid[v] = found;
            end else begin
                own = int'(r_owner[v]);
                w_cand_in[v]    = r_owner[v];
                w_cand_valid[v] = w_lane_valid[own] && int'(w_lane_vc[own]) == v &&
                                  !is_head(w_lane_type[own]);
            end
        end
    end

    // Output allocation: first VC at or after vc_ptr with a candidate and credit.
    logic             w_grant;
    logic [VC_W-1:0]  w_gnt_vc;
    logic [IN_W-1:0]  w_gnt_in;
    logic             w_xfer;
    flit_type_t       w_gnt_type;
    logic [FLIT_W-1:0] w_gnt_flit;

    always_comb begin
        int vidx;
        vidx     = 0;
        w_grant  = 1'b0;
        w_gnt_vc = '0;
        w_gnt_in = '0;
        for (int k = 0; k < N_VC; k++) begin
            vidx = (int'(r_vc_ptr) + k) % N_VC;
            if (!w_grant && w_cand_valid[vidx] && r_credit[vidx] != '0) begin
                w_grant  = 1'b1;
                w_gnt_vc = VC_W'(vidx);
                w_gnt_in = w_cand_in[vidx];
            end
        end
    end

    assign w_xfer     = w_grant && !arst;
    assign w_gnt_type = w_lane_type[w_gnt_in];
    assign w_gnt_flit = w_lane_flit[w_gnt_in];

    // Ready is one-hot on the granted input and held low during reset.
    always_comb begin
        fin_resp_o = '0;
        if (w_xfer) fin_resp_o[w_gnt_in] = 1'b1;
    end

    // Protocol error detection for the current cycle.
    logic w_err_det;

    always_comb begin
        w_err_det = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (w_lane_valid[i]) begin
                if (int'(w_lane_vc[i]) >= N_VC) begin
                    w_err_det = 1'b1;
                end else if (r_lock[w_lane_vc[i]] == VC_UNLOCKED) begin
                    if (!is_head(w_lane_type[i])) w_err_det = 1'b1;
                end else if (r_owner[w_lane_vc[i]] == IN_W'(i) && is_head(w_lane_type[i])) begin
                    w_err_det = 1'b1;
                end
            end
        end
        if (w_cr_valid) begin
            if (int'(w_cr_vc) >= N_VC) begin
                w_err_det = 1'b1;
            end else if (r_credit[w_cr_vc] == CNT_W'(BUF_DEPTH) &&
                         !(w_xfer && w_gnt_vc == w_cr_vc)) begin
                w_err_det = 1'b1;
            end
        end
    end

    // Lock FSM next state: head locks, tail unlocks, head/head-tail move in_ptr.
    lock_state_t     w_lock_nxt   [N_VC];
    logic [IN_W-1:0] w_owner_nxt  [N_VC];
    logic [IN_W-1:0] w_in_ptr_nxt [N_VC];
    logic [IN_W-1:0] w_in_after;

    assign w_in_after = IN_W'((int'(w_gnt_in) + 1) % N_IN);

    always_comb begin
        for (int v = 0; v < N_VC; v++) begin
            w_lock_nxt[v]   = r_lock[v];
            w_owner_nxt[v]  = r_owner[v];
            w_in_ptr_nxt[v] = r_in_ptr[v];
        end
        if (w_xfer) begin
            case (w_gnt_type)
                FT_HEAD: begin
                    w_lock_nxt[w_gnt_vc]   = VC_LOCKED;
                    w_owner_nxt[w_gnt_vc]  = w_gnt_in;
                    w_in_ptr_nxt[w_gnt_vc] = w_in_after;
                end
                FT_HEADTAIL: w_in_ptr_nxt[w_gnt_vc] = w_in_after;
                FT_TAIL:     w_lock_nxt[w_gnt_vc]   = VC_UNLOCKED;
                default:     ;
            endcase
        end
    end

    // Credit next value: send decrements, valid return increments, both cancel.
    logic [CNT_W-1:0] w_credit_nxt [N_VC];

    always_comb begin
        logic dec;
        logic inc;
        dec = 1'b0;
        inc = 1'b0;
        for (int v = 0; v < N_VC; v++) begin
            dec = w_xfer && (w_gnt_vc == VC_W'(v));
            inc = w_cr_valid && (w_cr_vc == VC_W'(v)) &&
                  (r_credit[v] != CNT_W'(BUF_DEPTH) || dec);
            w_credit_nxt[v] = r_credit[v] - CNT_W'(dec) + CNT_W'(inc);
        end
    end

    // Lock FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (arst) begin
            for (int v = 0; v < N_VC; v++) begin
                r_lock[v]   <= VC_UNLOCKED;
                r_owner[v]  <= '0;
                r_in_ptr[v] <= '0;
            end
        end else begin
            r_lock   <= w_lock_nxt;
            r_owner  <= w_owner_nxt;
            r_in_ptr <= w_in_ptr_nxt;
        end
    end

    // Credits, VC pointer, output link register and sticky error flag.
    always_ff @(posedge clk) begin
        if (arst) begin
            for (int v = 0; v < N_VC; v++) r_credit[v] <= CNT_W'(BUF_DEPTH);
            r_vc_ptr <= '0;
            r_fout   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_credit <= w_credit_nxt;
            if (w_xfer) r_vc_ptr <= VC_W'((int'(w_gnt_vc) + 1) % N_VC);
            r_fout   <= w_xfer ? {1'b1, w_gnt_vc, w_gnt_flit} : '0;
            r_err    <= r_err | w_err_det;
        end
    end

    assign fout_req_o = r_fout;
    assign err_o      = r_err;

endmodule
